// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared types and constants for the ring-oscillator PUF
// measurement sequencer.
//   state_t  - sequencer states (exposed on the controller's state_dbg port)
//   CW       - default edge-counter width
//   CLR_CYC  - cycles the counter clear is held before each window
//   max3     - helper used to size the phase timer
package puf_ctrl_pkg;

    localparam int CW      = 16;
    localparam int CLR_CYC = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/puf_window_timer.sv
// puf_window_timer: loadable down-counter shared by the CLEAR, RUN and
// SETTLE phases.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - start a new interval of (load_val + 1) cycles
//   load_val   - interval length minus one
//   done       - single-cycle pulse in the last cycle of the interval
module puf_window_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] cnt;
    logic          active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Only pulses while an interval is live, so a stale zero count in
    // IDLE never looks like a phase end.
    assign done = active && (cnt == '0);

endmodule

// File: rtl/puf_measure_ctrl.sv
// puf_measure_ctrl: sequencer for the ring-oscillator PUF measurement path.
// For each of RESP_BITS oscillator pairs it clears the counters, runs the
// oscillators for WINDOW cycles, waits SETTLE cycles, compares the counts
// and shifts one response bit into resp_data.
//   req_valid/req_ready/req_chal     - challenge handshake
//   abort                            - synchronous cancel of a measurement
//   osc_en, cnt_clr, sel_a, sel_b    - oscillator bank / counter controls
//   count_a, count_b                 - chain counts, quasi-static after SETTLE
//   resp_valid/resp_ready/resp_data/resp_weak - response handshake
//   busy                             - not idle
//   state_dbg                        - current sequencer state (state_t)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE; once resp_valid rises,
// resp_data and resp_weak hold until the transfer completes.
module puf_measure_ctrl #(
    parameter int RESP_BITS = 8,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 4,
    parameter int MARGIN    = 8,
    parameter int CW        = puf_ctrl_pkg::CW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_chal,
    input  logic                 abort,
    output logic                 osc_en,
    output logic                 cnt_clr,
    output logic [3:0]           sel_a,
    output logic [3:0]           sel_b,
    input  logic [CW-1:0]        count_a,
    input  logic [CW-1:0]        count_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_weak,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    import puf_ctrl_pkg::*;

    localparam int TW = $clog2(max3(WINDOW, SETTLE, 2));
    localparam int IW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [CW:0] MARGIN_W = (CW + 1)'(MARGIN);

    state_t        state, state_next;
    logic [IW-1:0] bit_idx;
    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_done;
    logic          abort_hit;
    logic          last_bit;
    logic          a_gt_b;
    logic [CW:0]   diff;
    logic          is_weak;

    puf_window_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // Absolute difference at CW+1 bits so extreme counts cannot wrap.
    always_comb begin
        a_gt_b  = (count_a > count_b);
        diff    = a_gt_b ? ({1'b0, count_a} - {1'b0, count_b})
                         : ({1'b0, count_b} - {1'b0, count_a});
        is_weak = (diff < MARGIN_W);
    end

    assign last_bit = (bit_idx == IW'(RESP_BITS - 1));

    always_comb begin
        state_next = state;
        t_load     = 1'b0;
        t_val      = '0;
        abort_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_CLEAR;
                    t_load     = 1'b1;
                    t_val      = TW'(CLR_CYC - 1);
                end
            end
            S_CLEAR: begin
                if (t_done) begin
                    state_next = S_RUN;
                    t_load     = 1'b1;
                    t_val      = TW'(WINDOW - 1);
                end
            end
            S_RUN: begin
                if (t_done) begin
                    state_next = S_SETTLE;
                    t_load     = 1'b1;
                    t_val      = TW'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (t_done) begin
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_CLEAR;
                    t_load     = 1'b1;
                    t_val      = TW'(CLR_CYC - 1);
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Abort only cancels an in-flight measurement; a finished response
        // and an idle controller are left alone.
        if (abort && (state != S_IDLE) && (state != S_DONE)) begin
            abort_hit  = 1'b1;
            state_next = S_IDLE;
            t_load     = 1'b0;
        end
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            osc_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            resp_valid <= 1'b0;
            sel_a      <= '0;
            sel_b      <= '0;
            bit_idx    <= '0;
            resp_data  <= '0;
            resp_weak  <= 1'b0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == S_IDLE);
            busy       <= (state_next != S_IDLE);
            osc_en     <= (state_next == S_RUN);
            cnt_clr    <= (state_next == S_CLEAR);
            resp_valid <= (state_next == S_DONE);
            if ((state == S_IDLE) && req_valid) begin
                sel_a     <= req_chal[3:0];
                sel_b     <= req_chal[7:4];
                bit_idx   <= '0;
                resp_data <= '0;
                resp_weak <= 1'b0;
            end else if (abort_hit) begin
                resp_data <= '0;
                resp_weak <= 1'b0;
            end else if (state == S_COMPARE) begin
                resp_data[bit_idx] <= a_gt_b;
                resp_weak          <= resp_weak | is_weak;
                // Selects step by one per bit and wrap mod 16 naturally.
                if (!last_bit) begin
                    bit_idx <= bit_idx + 1'b1;
                    sel_a   <= sel_a + 4'd1;
                    sel_b   <= sel_b + 4'd1;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
module tb_puf_measure_ctrl;

  localparam int RESP_BITS = 4;
  localparam int WINDOW    = 16;
  localparam int SETTLE    = 4;
  localparam int MARGIN    = 8;
  localparam int CW        = 16;
  localparam int LATENCY   = 92;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [7:0]           req_chal = '0;
  logic                 abort = 1'b0;
  logic                 osc_en;
  logic                 cnt_clr;
  logic [3:0]           sel_a;
  logic [3:0]           sel_b;
  logic [CW-1:0]        count_a;
  logic [CW-1:0]        count_b;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_weak;
  logic                 busy;
  logic [2:0]           state_dbg;

  puf_measure_ctrl #(
    .RESP_BITS (RESP_BITS),
    .WINDOW    (WINDOW),
    .SETTLE    (SETTLE),
    .MARGIN    (MARGIN),
    .CW        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chal   (req_chal),
    .abort      (abort),
    .osc_en     (osc_en),
    .cnt_clr    (cnt_clr),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .count_a    (count_a),
    .count_b    (count_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_weak  (resp_weak),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Counter model: counts keyed by the chain-A select of the current pair.
  logic [CW-1:0] tab_a [16];
  logic [CW-1:0] tab_b [16];
  always_comb begin
    count_a = tab_a[sel_a];
    count_b = tab_b[sel_a];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];   // {resp_weak, resp_data}
  logic [7:0] sel_q[$];   // {sel_b, sel_a} expected at each CLEAR
  int acc_cyc = 0;
  bit wave_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  logic prev_rv = 1'b0, prev_clr = 1'b0, prev_osc = 1'b0;
  int   osc_len = 0, clr_len = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0; prev_clr = 1'b0; prev_osc = 1'b0;
      osc_len = 0; clr_len = 0;
    end else begin
      if (resp_valid && !prev_rv)
        chk("resp_latency", cyc - acc_cyc, LATENCY);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {27'd0, resp_weak, resp_data}, 32'hFFFF_FFFF);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          chk("resp_data", {28'd0, resp_data}, {28'd0, e[3:0]});
          chk("resp_weak", {31'd0, resp_weak}, {31'd0, e[4]});
        end
      end
      if (cnt_clr && !prev_clr) begin
        if (sel_q.size() == 0) begin
          chk("unexpected_clear", {24'd0, sel_b, sel_a}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] s;
          s = sel_q.pop_front();
          chk("sel_a", {28'd0, sel_a}, {28'd0, s[3:0]});
          chk("sel_b", {28'd0, sel_b}, {28'd0, s[7:4]});
        end
      end
      if (wave_en && osc_en && !prev_osc) begin
        chk("no_overlap", {31'd0, cnt_clr}, 0);
        chk("clr_adjacent", {31'd0, prev_clr}, 1);
        chk("clr_len", clr_len, 2);
      end
      if (wave_en && !osc_en && prev_osc)
        chk("osc_len", osc_len, WINDOW);
      osc_len  = osc_en  ? osc_len + 1 : 0;
      clr_len  = cnt_clr ? clr_len + 1 : 0;
      prev_rv  = resp_valid;
      prev_clr = cnt_clr;
      prev_osc = osc_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tab(input int idx, input int a, input int b);
    tab_a[idx] = CW'(a);
    tab_b[idx] = CW'(b);
  endtask

  task automatic fill_tab(input int a, input int b);
    for (int k = 0; k < 16; k++) set_tab(k, a, b);
  endtask

  task automatic send(input logic [7:0] chal, input logic [4:0] exp, input bit push_resp, input int nsel);
    int guard;
    logic [3:0] sa, sb;
    sa = chal[3:0];
    sb = chal[7:4];
    for (int k = 0; k < nsel; k++) begin
      sel_q.push_back({sb, sa});
      sa = sa + 4'd1;
      sb = sb + 4'd1;
    end
    if (push_resp) exp_q.push_back(exp);
    guard = 0;
    while (!req_ready && guard < 200) begin
      step();
      guard++;
    end
    if (!req_ready) fail_now("req_ready_wait");
    req_valid = 1'b1;
    req_chal  = chal;
    step();
    req_valid = 1'b0;
    acc_cyc   = cyc;
    chk("ready_low_after_accept", {31'd0, req_ready}, 0);
    chk("busy_after_accept", {31'd0, busy}, 1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!(resp_valid && resp_ready) && guard < 400) begin
      step();
      guard++;
    end
    if (!(resp_valid && resp_ready)) begin
      fail_now("resp_wait");
    end else begin
      step();
      chk("ready_after_handshake", {31'd0, req_ready}, 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_osc_en"}, {31'd0, osc_en}, 0);
    chk({tag, "_cnt_clr"}, {31'd0, cnt_clr}, 0);
    chk({tag, "_sels"}, {24'd0, sel_b, sel_a}, 0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 0);
    chk({tag, "_resp_data"}, {28'd0, resp_data}, 0);
    chk({tag, "_resp_weak"}, {31'd0, resp_weak}, 0);
    chk({tag, "_state"}, {29'd0, state_dbg}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    fill_tab(100, 50);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    step();

    // Basic: every pair a=100/b=50.
    send(8'h31, {1'b0, 4'hF}, 1'b1, 4);
    wait_done();

    // Wrap and tie (back-to-back): pair 2 (sel_a=0) ties.
    fill_tab(90, 10);
    set_tab(0, 40, 40);
    send(8'hFE, {1'b1, 4'b1011}, 1'b1, 4);
    wait_done();

    // Equal selects and margin boundaries: diff exactly 8 is strong,
    // extreme counts must not wrap.
    set_tab(5, 108, 100);
    set_tab(6, 50, 58);
    set_tab(7, 0, 65535);
    set_tab(8, 65535, 0);
    send(8'h55, {1'b0, 4'b1001}, 1'b1, 4);
    wait_done();

    // Backpressure, diff 7 is weak.
    fill_tab(200, 193);
    resp_ready = 1'b0;
    send(8'h00, {1'b1, 4'hF}, 1'b1, 4);
    guard = 0;
    while (!resp_valid && guard < 200) begin
      step();
      guard++;
    end
    if (!resp_valid) fail_now("bp_valid_wait");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_valid", {31'd0, resp_valid}, 1);
      chk("bp_data", {28'd0, resp_data}, 4'hF);
      chk("bp_weak", {31'd0, resp_weak}, 1);
      chk("bp_ready", {31'd0, req_ready}, 0);
    end
    resp_ready = 1'b1;
    wait_done();

    // Abort during bit 1 RUN.
    fill_tab(100, 50);
    wave_en = 1'b0;
    send(8'h31, 5'd0, 1'b0, 2);
    while (cyc < acc_cyc + 29) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_osc_en", {31'd0, osc_en}, 0);
    chk("abort_cnt_clr", {31'd0, cnt_clr}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, req_ready}, 1);
    chk("abort_resp_data", {28'd0, resp_data}, 0);
    chk("abort_sel_q", sel_q.size(), 0);
    repeat (5) step();
    wave_en = 1'b1;
    send(8'h31, {1'b0, 4'hF}, 1'b1, 4);
    wait_done();

    // Reset during SETTLE of bit 3.
    send(8'h31, 5'd0, 1'b0, 4);
    while (cyc < acc_cyc + 88) step();
    chk("pre_reset_busy", {31'd0, busy}, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", {31'd0, req_ready}, 1);
    chk("post_reset_busy", {31'd0, busy}, 0);
    repeat (3) step();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("sel_q_empty", sel_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/puf_measure_ctrl.md
# puf_measure_ctrl

Sequencer for the ring-oscillator PUF measurement datapath. It accepts a challenge and, for each response bit, derives a pair of oscillator selects. For each pair it clears the two edge counters, enables the oscillators for a fixed window, stops them, waits for the counters to settle, compares the counts and shifts in one response bit. It sits between the host-side challenge/response handshake and the two oscillator-bank/mux/counter chains plus the comparator path.

## Interface
Parameters:
- RESP_BITS, 8: response bits generated per challenge (1..16).
- WINDOW, 1024: osc_en high cycles per measurement (≥1).
- SETTLE, 4: cycles after osc_en falls before counts are sampled (≥2).
- MARGIN, 8: |count_a − count_b| below this marks the bit weak.
- CW, 16: counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- req_valid  in  1  challenge offered.
- req_ready  out  1  high only in IDLE.
- req_chal  in  8  challenge: [3:0] base select A, [7:4] base select B.
- abort  in  1  synchronous cancel.
- osc_en  out  1  oscillator enable to both banks.
- cnt_clr  out  1  counter clear to both chains.
- sel_a  out  4  mux select, chain A.
- sel_b  out  4  mux select, chain B.
- count_a  in  CW  chain A count.
- count_b  in  CW  chain B count.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_data  out  RESP_BITS  response; bit i is the result of pair i.
- resp_weak  out  1  at least one bit had margin < MARGIN.
- busy  out  1  not IDLE.

## Operation
- States: IDLE → CLEAR → RUN → SETTLE → COMPARE → (CLEAR for the next bit | DONE) → IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_chal, set i=0, clear resp_data and resp_weak, go to CLEAR.
- Selects for bit i: sel_a=(chal[3:0]+i) mod 16 and sel_b=(chal[7:4]+i) mod 16. Both wrap and both are held constant from CLEAR through COMPARE.
- CLEAR: 2 cycles, cnt_clr=1, osc_en=0.
- RUN: WINDOW cycles, osc_en=1, cnt_clr=0.
- SETTLE: SETTLE cycles, osc_en=0. The counts are treated as quasi-static after this, so there is no synchronizer.
- COMPARE: 1 cycle.
  - Sample the counts.
  - Set resp_data[i]=(count_a>count_b), unsigned. A tie gives 0.
  - Set resp_weak |= (|count_a−count_b| < MARGIN). The difference is computed at CW+1 bits, so there is no wrap.
  - If i==RESP_BITS−1, go to DONE; else increment i and go to CLEAR.
- DONE: resp_valid=1 and resp_data is held stable. On resp_valid&&resp_ready go to IDLE.
- sel_a==sel_b is legal. The pair is measured normally; the expected result is a tie, giving bit 0 and weak.
- abort:
  - In any state except IDLE/DONE, the next state is IDLE. osc_en and cnt_clr drop in the same cycle, no response is produced, and resp_data is cleared.
  - Ignored in IDLE and DONE.
- abort and req_valid together in IDLE: the request is accepted, because abort is ignored in IDLE.

## Timing
- All outputs are registered.
- Reset values: req_ready=1, busy=0, osc_en=0, cnt_clr=0, sel_a=0, sel_b=0, resp_valid=0, resp_data=0, resp_weak=0.
- Per bit: T = 3 + WINDOW + SETTLE cycles.
- resp_valid rises RESP_BITS·T cycles after the accept edge.
- req_ready is low the cycle after accept.
- Back-to-back: a new request can be accepted in the cycle after the response handshake.
- Reset mid-operation: all outputs take their reset values immediately and osc_en falls asynchronously.

## Structure
- Package puf_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE);
  - CW;
  - CLR_CYC=2.
- One sub-module, puf_window_timer: a loadable down-counter with a done pulse. It is reused for the CLEAR, RUN and SETTLE phases and is sized by clog2(max(WINDOW,SETTLE,2)).

## Test plan
Bench parameters: RESP_BITS=4, WINDOW=16, SETTLE=4, MARGIN=8, so T=23.
- Basic: chal=8'h31, count model returns a=100/b=50 for every pair → sel_a 1,2,3,4 and sel_b 3,4,5,6 in sequence; resp_valid at accept+92; resp_data=4'hF; resp_weak=0.
- Wrap and ties: chal=8'hFE → selects (E,F),(F,0),(0,1),(1,2); model a=b=40 on pair 2 only, a=90/b=10 elsewhere → resp_data=4'b1011, resp_weak=1.
- Waveform: osc_en high for exactly 16 cycles per bit; cnt_clr high for exactly 2 cycles preceding each RUN; never both high together.
- Abort: abort in cycle 30 (bit 1, RUN) → next cycle IDLE, osc_en=0, busy=0, no resp_valid; a fresh request then completes normally.
- Backpressure: resp_ready held low 10 cycles → resp_valid and resp_data stable, req_ready=0 throughout; after the handshake, req_ready=1 next cycle.
- Reset: rst_n low during SETTLE of bit 3 → all outputs reach their reset values asynchronously; after release, IDLE with req_ready=1.
